// File: rtl/reset_request_scheduler.sv
// reset_request_scheduler
//   Collects reset requests from several on-chip sources (CSR soft reset,
//   I3C RSTACT handler, watchdog) and serialises them round-robin onto the
//   single sw_rst / i3c_rst_req pair of the I3C slave reset controller.
//   Each grant drives one request line until the controller reports
//   reset_active. It then waits for reset_done, acks the requester and
//   idles for a cooldown period. A stalled handshake times out and sets a
//   sticky error flag.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_pulse[N]        request pulse or level, latched into pending
//   req_kind[N]         0 = software reset, 1 = I3C reset (sampled at grant)
//   req_mask[N]         1 = requester not eligible for grant (pending kept)
//   reset_active_i      reset_active from the reset controller
//   reset_done_i        reset_done from the reset controller
//   err_clr             clears timeout_err
//   sw_rst_o            to the controller's sw_rst input
//   i3c_rst_req_o       to the controller's i3c_rst_req input
//   req_ack[N]          one-hot, 1-cycle completion pulse
//   ack_err             qualifies req_ack: 1 = completed by timeout
//   pending_o[N]        latched pending bits
//   grant_id            id of the current or last grant
//   busy                scheduler not idle
//   timeout_err         sticky timeout flag
module reset_request_scheduler #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ACK_TIMEOUT     = 64,
    parameter int unsigned COOLDOWN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_pulse,
    input  logic [NUM_REQ-1:0]         req_kind,
    input  logic [NUM_REQ-1:0]         req_mask,
    input  logic                       reset_active_i,
    input  logic                       reset_done_i,
    input  logic                       err_clr,
    output logic                       sw_rst_o,
    output logic                       i3c_rst_req_o,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       ack_err,
    output logic [NUM_REQ-1:0]         pending_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned IDW     = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (ACK_TIMEOUT > COOLDOWN_CYCLES) ? ACK_TIMEOUT : COOLDOWN_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRIVE     = 2'd1,
        WAIT_DONE = 2'd2,
        COOLDOWN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] eligible, grant_clr;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     sel_idx;
    logic [IDW:0]       cand;
    logic               found;
    logic               kind_q, kind_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sw_rst_q, sw_rst_d;
    logic               i3c_q, i3c_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               ack_err_q, ack_err_d;
    logic               terr_q, terr_d;
    logic               done_evt, tmo_evt;

    // Round-robin search: first eligible index at or above rr_ptr, wrapping.
    // cand carries one extra bit so rr_ptr + i never overflows before the
    // modulo-NUM_REQ correction (NUM_REQ need not be a power of two).
    always_comb begin
        eligible = pending_q & ~req_mask;
        found    = 1'b0;
        sel_idx  = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && eligible[cand[IDW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        kind_d     = kind_q;
        grant_clr  = '0;
        done_evt   = 1'b0;
        tmo_evt    = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants wait out any externally caused reset in progress.
                if (found && !reset_active_i && reset_done_i) begin
                    state_d             = DRIVE;
                    grant_id_d          = sel_idx;
                    rr_ptr_d            = (sel_idx == IDW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                    kind_d              = req_kind[sel_idx];
                    grant_clr[sel_idx]  = 1'b1;
                end
            end
            DRIVE: begin
                if (reset_active_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    tmo_evt = 1'b1;
                    state_d = COOLDOWN;
                end
            end
            WAIT_DONE: begin
                if (!reset_active_i && reset_done_i) begin
                    done_evt = 1'b1;
                    state_d  = COOLDOWN;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    tmo_evt = 1'b1;
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cnt_q == CW'(COOLDOWN_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request in its own grant cycle re-queues (set beats clear).
        pending_d = (pending_q & ~grant_clr) | req_pulse;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Request lines are registered from the next state so they rise the
        // cycle after the grant and fall as soon as DRIVE is left.
        sw_rst_d = (state_d == DRIVE) & ~kind_d;
        i3c_d    = (state_d == DRIVE) &  kind_d;

        ack_d = '0;
        if (done_evt || tmo_evt) begin
            ack_d[grant_id_q] = 1'b1;
        end
        ack_err_d = tmo_evt;
        terr_d    = tmo_evt | (terr_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            kind_q     <= 1'b0;
            cnt_q      <= '0;
            sw_rst_q   <= 1'b0;
            i3c_q      <= 1'b0;
            ack_q      <= '0;
            ack_err_q  <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            sw_rst_q   <= sw_rst_d;
            i3c_q      <= i3c_d;
            ack_q      <= ack_d;
            ack_err_q  <= ack_err_d;
            terr_q     <= terr_d;
        end
    end

    assign sw_rst_o      = sw_rst_q;
    assign i3c_rst_req_o = i3c_q;
    assign req_ack       = ack_q;
    assign ack_err       = ack_err_q;
    assign pending_o     = pending_q;
    assign grant_id      = grant_id_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_reset_request_scheduler.sv
// tb_reset_request_scheduler
//   Directed bench for reset_request_scheduler (NUM_REQ=4, ACK_TIMEOUT=64,
//   COOLDOWN_CYCLES=8). Inputs change and outputs are sampled 1 ns after
//   the rising clock edge; the reset-controller handshake is driven inline.
module tb_reset_request_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_pulse = '0;
    logic [3:0] req_kind = '0;
    logic [3:0] req_mask = '0;
    logic       reset_active_i = 1'b0;
    logic       reset_done_i = 1'b1;
    logic       err_clr = 1'b0;
    logic       sw_rst_o;
    logic       i3c_rst_req_o;
    logic [3:0] req_ack;
    logic       ack_err;
    logic [3:0] pending_o;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int excl_viol = 0;
    bit sw_seen  = 1'b0;
    bit ack_seen = 1'b0;

    reset_request_scheduler #(
        .NUM_REQ        (4),
        .ACK_TIMEOUT    (64),
        .COOLDOWN_CYCLES(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_pulse     (req_pulse),
        .req_kind      (req_kind),
        .req_mask      (req_mask),
        .reset_active_i(reset_active_i),
        .reset_done_i  (reset_done_i),
        .err_clr       (err_clr),
        .sw_rst_o      (sw_rst_o),
        .i3c_rst_req_o (i3c_rst_req_o),
        .req_ack       (req_ack),
        .ack_err       (ack_err),
        .pending_o     (pending_o),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sw_rst_o && i3c_rst_req_o) excl_viol++;
        if (sw_rst_o) sw_seen = 1'b1;
        if (|req_ack) ack_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_pulse      = '0;
        req_mask       = '0;
        reset_active_i = 1'b0;
        reset_done_i   = 1'b1;
        err_clr        = 1'b0;
        rst            = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic pulse(input logic [3:0] v);
        req_pulse = v;
        step(1);
        req_pulse = '0;
    endtask

    // Wait for a grant, check it, run a short handshake, check the ack and
    // wait for the scheduler to return to idle.
    task automatic serve(input int id, input logic kind, input string tag);
        int n;
        n = 0;
        while (!(sw_rst_o || i3c_rst_req_o) && n < 30) begin
            step(1);
            n++;
        end
        chk({tag, "_grant"}, 32'(grant_id), 32'(id));
        chk({tag, "_line"}, 32'({i3c_rst_req_o, sw_rst_o}), kind ? 32'd2 : 32'd1);
        step(2);
        reset_active_i = 1'b1;
        reset_done_i   = 1'b0;
        step(3);
        reset_active_i = 1'b0;
        reset_done_i   = 1'b1;
        n = 0;
        while (req_ack == 4'b0 && n < 10) begin
            step(1);
            n++;
        end
        chk({tag, "_ack"}, 32'(req_ack), 32'(1 << id));
        chk({tag, "_ackerr"}, 32'(ack_err), 32'd0);
        n = 0;
        while (busy && n < 20) begin
            step(1);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int hi;
        int n;

        // Reset values
        #2 rst = 1'b1;
        step(2);
        chk("rst_outputs", 32'({sw_rst_o, i3c_rst_req_o, req_ack, ack_err, pending_o,
                                grant_id, busy, timeout_err}), 32'd0);
        rst = 1'b0;
        step(1);

        // Single software reset on requester 1
        req_kind = 4'b0000;
        pulse(4'b0010);
        chk("t1_pending", 32'(pending_o), 32'h2);
        chk("t1_not_busy", 32'(busy), 32'd0);
        step(1);
        chk("t1_grant_line", 32'({busy, sw_rst_o, i3c_rst_req_o}), 32'b110);
        chk("t1_grant_id", 32'(grant_id), 32'd1);
        chk("t1_pending_clr", 32'(pending_o), 32'h0);
        hi = 0;
        repeat (11) begin
            if (sw_rst_o && !i3c_rst_req_o) hi++;
            step(1);
        end
        chk("t1_sw_high", 32'(hi), 32'd11);
        chk("t1_sw_still", 32'(sw_rst_o), 32'd1);
        reset_active_i = 1'b1;
        reset_done_i   = 1'b0;
        step(1);
        chk("t1_sw_drop", 32'({sw_rst_o, busy}), 32'b01);
        step(24);
        chk("t1_no_early_ack", 32'(req_ack), 32'h0);
        reset_active_i = 1'b0;
        reset_done_i   = 1'b1;
        step(1);
        chk("t1_ack", 32'(req_ack), 32'h2);
        chk("t1_ackerr", 32'(ack_err), 32'd0);
        step(1);
        chk("t1_ack_1cyc", 32'(req_ack), 32'h0);
        step(6);
        chk("t1_cool_busy", 32'(busy), 32'd1);
        step(1);
        chk("t1_cool_done", 32'(busy), 32'd0);
        chk("t1_no_terr", 32'(timeout_err), 32'd0);

        // Round robin 0,1,3 then 0 before 3 after the wrap
        do_reset();
        pulse(4'b1011);
        chk("rr_pending", 32'(pending_o), 32'hB);
        serve(0, 1'b0, "rr_a");
        serve(1, 1'b0, "rr_b");
        serve(3, 1'b0, "rr_c");
        pulse(4'b1001);
        serve(0, 1'b0, "rr_d");
        serve(3, 1'b0, "rr_e");

        // I3C kind on requester 2
        req_kind = 4'b0100;
        sw_seen  = 1'b0;
        pulse(4'b0100);
        serve(2, 1'b1, "i3c");
        chk("i3c_no_sw", 32'(sw_seen), 32'd0);
        req_kind = 4'b0000;

        // Timeout on requester 0
        pulse(4'b0001);
        n = 0;
        while (!sw_rst_o && n < 10) begin
            step(1);
            n++;
        end
        hi = 0;
        while (sw_rst_o && hi < 100) begin
            hi++;
            step(1);
        end
        chk("to_sw_cycles", 32'(hi), 32'd64);
        chk("to_ack", 32'(req_ack), 32'h1);
        chk("to_ackerr", 32'(ack_err), 32'd1);
        chk("to_terr", 32'(timeout_err), 32'd1);
        step(20);
        chk("to_terr_sticky", 32'({timeout_err, busy}), 32'b10);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("to_terr_clr", 32'(timeout_err), 32'd0);

        // Mask holds a pending request
        req_mask = 4'b0001;
        pulse(4'b0001);
        step(5);
        chk("mask_pending", 32'(pending_o), 32'h1);
        chk("mask_no_grant", 32'(busy), 32'd0);
        req_mask = 4'b0000;
        serve(0, 1'b0, "unmask");

        // External reset in progress blocks grants
        reset_active_i = 1'b1;
        reset_done_i   = 1'b0;
        pulse(4'b0010);
        step(5);
        chk("ext_active_block", 32'({busy, pending_o}), 32'h02);
        reset_active_i = 1'b0;
        step(3);
        chk("ext_done_block", 32'({busy, pending_o}), 32'h02);
        reset_done_i = 1'b1;
        serve(1, 1'b0, "ext");

        // rst asserted in WAIT_DONE
        pulse(4'b0100);
        n = 0;
        while (!sw_rst_o && n < 10) begin
            step(1);
            n++;
        end
        step(1);
        reset_active_i = 1'b1;
        reset_done_i   = 1'b0;
        req_pulse      = 4'b1000;
        step(1);
        req_pulse = '0;
        step(1);
        chk("mid_wait_state", 32'({busy, sw_rst_o, pending_o}), 32'b1_0_1000);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({sw_rst_o, i3c_rst_req_o, req_ack, ack_err, pending_o,
                                    grant_id, busy, timeout_err}), 32'd0);
        reset_active_i = 1'b0;
        reset_done_i   = 1'b1;
        step(2);
        rst      = 1'b0;
        ack_seen = 1'b0;
        step(15);
        chk("mid_no_ack", 32'(ack_seen), 32'd0);
        chk("mid_idle", 32'({busy, pending_o}), 32'd0);

        chk("exclusive", 32'(excl_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_request_scheduler.md
Name: reset_request_scheduler

Overview:
Arbitrates reset requests from multiple in-chip sources (CSR soft-reset writes, I3C RSTACT CCC handler, watchdog) onto the single sw_rst / i3c_rst_req input pair of the I3C slave reset controller. It latches request pulses and grants one at a time, round-robin. For each grant it holds the selected request line until the controller reports reset_active, then waits for reset_done. It enforces a cooldown between resets and flags handshake timeouts.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 64, max cycles allowed in DRIVE or in WAIT_DONE before a timeout error
COOLDOWN_CYCLES, 8, idle cycles after each reset before the next grant (>=1)

Ports:
clk  input  1  system clock, same domain as the reset controller
rst  input  1  asynchronous, active-high reset
req_pulse  input  NUM_REQ  per-requester request; a 1-cycle pulse or a level, latched into pending
req_kind  input  NUM_REQ  per-requester type, sampled at grant: 0 = software reset, 1 = I3C reset
req_mask  input  NUM_REQ  1 = requester ineligible for grant; its pending bit is kept
reset_active_i  input  1  reset_active from the reset controller
reset_done_i  input  1  reset_done from the reset controller
err_clr  input  1  clears timeout_err
sw_rst_o  output  1  to the controller's sw_rst input
i3c_rst_req_o  output  1  to the controller's i3c_rst_req input
req_ack  output  NUM_REQ  1-cycle completion pulse, one-hot
ack_err  output  1  qualifies req_ack: 1 = completed by timeout
pending_o  output  NUM_REQ  latched pending bits
grant_id  output  $clog2(NUM_REQ)  id of the current or last grant
busy  output  1  state != IDLE
timeout_err  output  1  sticky; set on any timeout

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pending, rr_ptr, grant_id, cnt = 0.
  - All outputs 0.
  - rst asserted mid-operation drops sw_rst_o / i3c_rst_req_o immediately; there is no completion ack.
- Pending:
  - pending[i] is set when req_pulse[i]=1.
  - pending[i] is cleared in the cycle requester i is granted.
  - If set and clear coincide for the same bit, set wins, so a request arriving during its own grant cycle is re-queued.
- Arbitration (IDLE only):
  - Eligible = pending & ~req_mask.
  - A grant is issued only when eligible != 0, reset_active_i=0 and reset_done_i=1; this blocks grants while an externally caused reset (POR/system) is in progress.
  - Selection: the first eligible index searching upward from rr_ptr with wrap-around.
  - On grant: grant_id <= index, rr_ptr <= index+1 mod NUM_REQ, kind_r <= req_kind[index], state <= DRIVE.
- Counter: cnt is cleared on every state change and increments each cycle in DRIVE, WAIT_DONE and COOLDOWN.
- DRIVE:
  - Registered outputs: sw_rst_o = ~kind_r, i3c_rst_req_o = kind_r.
  - The line is first high in the cycle after the grant.
  - If reset_active_i=1: go to WAIT_DONE.
  - Else if cnt == ACK_TIMEOUT-1: timeout, go to COOLDOWN.
- WAIT_DONE:
  - Both request outputs are 0.
  - If reset_active_i=0 and reset_done_i=1: success, go to COOLDOWN.
  - Else if cnt == ACK_TIMEOUT-1: timeout, go to COOLDOWN.
- Completion:
  - On the success or timeout transition, req_ack[grant_id]=1 for exactly 1 cycle (registered, visible in the first COOLDOWN cycle).
  - ack_err = 1 for a timeout, 0 for success.
- Timeout: sets timeout_err. err_clr clears it; if err_clr coincides with a new timeout, the set wins.
- COOLDOWN: outputs 0. When cnt == COOLDOWN_CYCLES-1, go to IDLE.
- Output exclusivity: sw_rst_o and i3c_rst_req_o are never 1 simultaneously, and both are 0 outside DRIVE.
- Mask changes:
  - req_mask is only sampled in IDLE.
  - Masking a requester after its grant has no effect on the reset in progress.

Test Plan:
- Single software reset. Stimulus: req_pulse[1] 1-cycle pulse, req_kind[1]=0; controller model raises reset_active_i 11 cycles after sw_rst_o rises and raises reset_done_i 25 cycles after that. Required response: sw_rst_o high exactly until the cycle after reset_active_i rises; req_ack=4'b0010 with ack_err=0 one cycle after reset_done_i; busy low 8 cycles later.
- Round-robin. Stimulus: req_pulse=4'b1011 in one cycle. Required response: grants in order 0, 1, 3; after that, a pulse on 0 together with a pulse on 3 grants 0 first (rr_ptr=0 after the wrap from 3).
- I3C kind. Stimulus: req_kind[2]=1, request on 2. Required response: only i3c_rst_req_o toggles; sw_rst_o stays 0 throughout.
- Timeout. Stimulus: reset_active_i tied 0, request on 0. Required response: sw_rst_o high for 64 cycles; req_ack[0]=1 with ack_err=1; timeout_err=1, held until err_clr.
- Mask and external reset. Stimulus: req_mask[0]=1 with request 0 pending. Required response: no grant and pending_o[0]=1; after the mask is cleared, the grant proceeds. Stimulus: reset_active_i forced high in IDLE with a request pending. Required response: no grant until reset_active_i=0 and reset_done_i=1.
- Reset mid-operation. Stimulus: rst asserted in WAIT_DONE. Required response: all outputs 0 in the same cycle, pending_o=0, and no req_ack after rst is released.
